cell_alloc_mp: RTL and testbench
================================

// Module: cell_alloc_mp
// PURPOSE
//  Parametrised free-list cell allocator for the packet buffer; successor to the 2-port allocator.
//  Hands out one cell ID per cycle to the ingress writer. Accepts freed IDs from FREE_PORT_NUM
//  egress/drop ports under round-robin arbitration. Exports occupancy and a programmable
//  pressure flag used by the PIFO drop logic.
// PARAMETERS
//  CELL_NUM       64                   number of buffer cells; power of two, >=4
//  CELL_ID_WIDTH  $clog2(CELL_NUM)     cell ID width
//  FREE_PORT_NUM  4                    number of free ports; 1..16
//  INTENSE_THRESH 32                   alloc_intense asserts when free_count <= this value
// PORTS
//  clk            in   1                     clock
//  rst            in   1                     reset; synchronous, active-high
//  init_done      out  1                     free list populated; block operational
//  alloc_req      in   1                     request one cell
//  alloc_gnt      out  1                     cell granted this cycle (combinational)
//  alloc_cell_id  out  CELL_ID_WIDTH         granted ID; valid only while alloc_gnt=1
//  alloc_intense  out  1                     free_count <= INTENSE_THRESH (registered)
//  free_count     out  CELL_ID_WIDTH+1       cells currently in the free list (registered)
//  free_req       in   FREE_PORT_NUM         per-port free valid
//  free_ready     out  FREE_PORT_NUM         per-port accept; one-hot or zero (combinational)
//  free_cell_id   in   FREE_PORT_NUM*CELL_ID_WIDTH   packed IDs; port i at [i*W +: W]
//  free_err       out  1                     1-cycle pulse on a rejected free (feature only)
// BEHAVIOUR
//  Free list
//  - RAM ring of CELL_NUM entries with async read.
//  - rd_ptr and wr_ptr each carry an extra wrap bit.
//  - Empty when the pointers are equal. Full when they differ only in the wrap bit.
//  States: INIT -> RUN
//  - Entered on reset, including reset asserted mid-operation. All in-flight state is discarded.
//  - INIT writes IDs 0..CELL_NUM-1, one per cycle, in ascending order.
//  - INIT lasts exactly CELL_NUM cycles. The first RUN cycle sets init_done=1.
//  - During INIT: alloc_gnt=0 and free_ready=0.
//  Reset values
//  - init_done=0, alloc_gnt=0, free_ready=0, free_err=0.
//  - free_count=0, alloc_intense=1, RR pointer=0.
//  Allocation
//  - alloc_gnt = alloc_req & init_done & !empty.
//  - alloc_cell_id = mem[rd_ptr]. rd_ptr increments on gnt. Zero-cycle latency.
//  - When empty: alloc_gnt=0 and the requester must retry. No stall state is kept.
//  Free arbitration
//  - Round-robin over asserted free_req bits, starting at the port after the last granted one.
//  - free_ready[i] = init_done & !full & (grant==i).
//  - On handshake: mem[wr_ptr] <= ID and wr_ptr increments.
//  - A freed cell becomes allocatable on the next cycle (1-cycle latency).
//  - At most one free per cycle. Ports that are not granted hold their request.
//  Count
//  - free_count is +1 on a free, -1 on an alloc, and unchanged when both happen in the same cycle.
//  - free_count is never below 0 and never above CELL_NUM.
//  - alloc_intense is recomputed from the next-state free_count.
//  Boundaries
//  - When full, every free_ready=0. This protects against overflow caused by a double free.
//  - Pointer wrap is handled by the extra pointer bit. No special-case logic is needed.
// CONFIGURATION
//  CELL_ALLOC_DOUBLE_FREE_CHECK_EN defined:
//  - Keep a CELL_NUM-bit allocated bitmap. Set a bit on alloc, clear it on free.
//  - A free of a cell whose bit is clear is still accepted (free_ready=1) but is not pushed.
//  - That rejected free leaves free_count unchanged and pulses free_err.
//  - A same-cycle alloc and free of the same ID counts as a legal free of the previously allocated state.
//  Not defined:
//  - No bitmap. Every accepted free is pushed. free_err is tied to 0.
// STRUCTURE
//  Package cell_alloc_pkg:
//  - cell_id_t typedef.
//  - State enum {ST_INIT, ST_RUN}.
//  - Function rr_pick(req, last) returning a one-hot grant.
//  Sub-module cell_free_list:
//  - Ring RAM plus pointers, full/empty and count.
//  - Push/pop ports. Simultaneous push and pop are legal.
//  - Instantiated once. Arbiter, FSM and bitmap live in the top module.
// TESTING
//  1 Reset, CELL_NUM=64: init_done rises in cycle 64.
//    Then 64 back-to-back allocs return IDs 0..63 in order.
//    The 65th alloc gets alloc_gnt=0, and free_count=0.
//  2 Free ports 0..3 all request continuously, 8 cycles:
//    grants go 0,1,2,3,0,1,2,3 with one free per cycle.
//  3 Same-cycle alloc and free at free_count=10: free_count stays 10.
//    The freed ID is allocatable on the next cycle.
//  4 alloc_intense: free_count 33->32 sets it to 1. 32->33 clears it.
//  5 rst asserted mid-traffic with 20 cells allocated:
//    INIT reruns, free_count returns to 64, and pending frees are dropped.
//  6 With CELL_ALLOC_DOUBLE_FREE_CHECK_EN, free ID 5 twice:
//    the second free pulses free_err and free_count rises only once.

Source files
------------

// File: rtl/cell_alloc_pkg.sv
// Shared types and helpers for the multi-port cell allocator.
package cell_alloc_pkg;

    localparam int unsigned CELL_NUM_DEF      = 64;
    localparam int unsigned CELL_ID_WIDTH_DEF = $clog2(CELL_NUM_DEF);
    localparam int unsigned MAX_FREE_PORTS    = 16;

    typedef logic [CELL_ID_WIDTH_DEF-1:0] cell_id_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // One-hot round-robin pick over the first n request bits; the search
    // begins at 'start', which holds the port after the last granted one.
    function automatic logic [MAX_FREE_PORTS-1:0] rr_pick(
        input logic [MAX_FREE_PORTS-1:0] req,
        input logic [3:0]                start,
        input int unsigned               n
    );
        logic [MAX_FREE_PORTS-1:0] gnt;
        logic [3:0]                idx;
        gnt = '0;
        for (int unsigned i = 0; i < n; i++) begin
            idx = 4'((32'(start) + i) % n);
            if (req[idx] && (gnt == '0)) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/cell_alloc_mp_free_list.sv
// Ring-RAM free list: async-read head, wrap-bit pointers, registered count.
module cell_free_list #(
    parameter int unsigned CELL_NUM      = 64,
    parameter int unsigned CELL_ID_WIDTH = $clog2(CELL_NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [CELL_ID_WIDTH-1:0] push_id,
    input  logic                     pop,
    output logic [CELL_ID_WIDTH-1:0] pop_id,
    output logic                     empty,
    output logic                     full,
    output logic [CELL_ID_WIDTH:0]   count,
    output logic [CELL_ID_WIDTH:0]   count_next
);

    localparam int unsigned W = CELL_ID_WIDTH;

    logic [W-1:0] mem [CELL_NUM];
    logic [W:0]   rd_ptr;
    logic [W:0]   wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[W] != wr_ptr[W]) && (rd_ptr[W-1:0] == wr_ptr[W-1:0]);
    assign pop_id  = mem[rd_ptr[W-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // Storage write; contents need no reset because INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[W-1:0]] <= push_id;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

endmodule

// File: rtl/cell_alloc_mp.sv
// Multi-port free-list cell allocator: one alloc per cycle, round-robin frees.
// Optional macro CELL_ALLOC_DOUBLE_FREE_CHECK_EN adds an allocated-cell bitmap
// that drops and flags frees of cells that are not currently allocated.
module cell_alloc_mp
    import cell_alloc_pkg::*;
#(
    parameter int unsigned CELL_NUM       = 64,
    parameter int unsigned CELL_ID_WIDTH  = $clog2(CELL_NUM),
    parameter int unsigned FREE_PORT_NUM  = 4,
    parameter int unsigned INTENSE_THRESH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    output logic                                   init_done,
    input  logic                                   alloc_req,
    output logic                                   alloc_gnt,
    output logic [CELL_ID_WIDTH-1:0]               alloc_cell_id,
    output logic                                   alloc_intense,
    output logic [CELL_ID_WIDTH:0]                 free_count,
    input  logic [FREE_PORT_NUM-1:0]               free_req,
    output logic [FREE_PORT_NUM-1:0]               free_ready,
    input  logic [FREE_PORT_NUM*CELL_ID_WIDTH-1:0] free_cell_id,
    output logic                                   free_err
);

    localparam int unsigned W = CELL_ID_WIDTH;

    state_t                    state;
    state_t                    state_nxt;
    logic                      run;
    logic [W-1:0]              init_cnt;
    logic [3:0]                rr_ptr;
    logic [MAX_FREE_PORTS-1:0] grant_ext;
    logic [3:0]                sel_idx;
    logic [W-1:0]              sel_id;
    logic                      free_fire;
    logic                      free_valid;
    logic                      push;
    logic [W-1:0]              push_id;
    logic                      empty;
    logic                      full;
    logic [W:0]                count_next;

    // State register and INIT ID counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    // Next state and run qualifier; INIT leaves after writing the last ID.
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        case (state)
            ST_INIT: if (init_cnt == W'(CELL_NUM - 1)) state_nxt = ST_RUN;
            ST_RUN:  run = 1'b1;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign init_done     = run;
    assign alloc_gnt     = alloc_req && run && !empty;

    assign grant_ext  = rr_pick(MAX_FREE_PORTS'(free_req), rr_ptr, FREE_PORT_NUM);
    assign free_ready = (run && !full) ? grant_ext[FREE_PORT_NUM-1:0] : '0;
    assign free_fire  = |free_ready;

    // Index of the granted free port.
    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < MAX_FREE_PORTS; i++) begin
            if (grant_ext[i]) sel_idx = 4'(i);
        end
    end

    assign sel_id = free_cell_id[32'(sel_idx)*W +: W];

    // Round-robin pointer moves past the port that completed a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (free_fire) begin
            rr_ptr <= (sel_idx == 4'(FREE_PORT_NUM - 1)) ? 4'd0 : sel_idx + 4'd1;
        end
    end

`ifdef CELL_ALLOC_DOUBLE_FREE_CHECK_EN
    logic [CELL_NUM-1:0] alloc_map;

    // A same-cycle alloc of the freed ID makes that free legal.
    assign free_valid = alloc_map[sel_id] || (alloc_gnt && (alloc_cell_id == sel_id));
    assign free_err   = free_fire && !free_valid;

    // Allocated-cell bitmap: set on alloc, cleared by a legal free.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_map <= '0;
        end else begin
            if (alloc_gnt) alloc_map[alloc_cell_id] <= 1'b1;
            if (free_fire && free_valid) alloc_map[sel_id] <= 1'b0;
        end
    end
`else
    assign free_valid = 1'b1;
    assign free_err   = 1'b0;
`endif

    assign push    = (state == ST_INIT) || (free_fire && free_valid);
    assign push_id = (state == ST_INIT) ? init_cnt : sel_id;

    cell_free_list #(
        .CELL_NUM      (CELL_NUM),
        .CELL_ID_WIDTH (CELL_ID_WIDTH)
    ) u_free_list (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_id    (push_id),
        .pop        (alloc_gnt),
        .pop_id     (alloc_cell_id),
        .empty      (empty),
        .full       (full),
        .count      (free_count),
        .count_next (count_next)
    );

    // Pressure flag tracks the occupancy the count register is about to hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_intense <= 1'b1;
        end else begin
            alloc_intense <= (32'(count_next) <= INTENSE_THRESH);
        end
    end

endmodule

// File: tb/tb_cell_alloc_mp.sv
// Self-checking bench for cell_alloc_mp (CELL_NUM=64, 4 free ports).
module tb_cell_alloc_mp;

    localparam int unsigned CN = 64;
    localparam int unsigned W  = 6;
    localparam int unsigned NP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_done;
    logic            alloc_req;
    logic            alloc_gnt;
    logic [W-1:0]    alloc_cell_id;
    logic            alloc_intense;
    logic [W:0]      free_count;
    logic [NP-1:0]   free_req;
    logic [NP-1:0]   free_ready;
    logic [NP*W-1:0] free_cell_id;
    logic            free_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [NP-1:0]   req;
        logic [NP-1:0]   exp_ready;
        logic [NP*W-1:0] ids;
    } vec_t;

    vec_t vecs[8];

    cell_alloc_mp #(
        .CELL_NUM       (CN),
        .CELL_ID_WIDTH  (W),
        .FREE_PORT_NUM  (NP),
        .INTENSE_THRESH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done     (init_done),
        .alloc_req     (alloc_req),
        .alloc_gnt     (alloc_gnt),
        .alloc_cell_id (alloc_cell_id),
        .alloc_intense (alloc_intense),
        .free_count    (free_count),
        .free_req      (free_req),
        .free_ready    (free_ready),
        .free_cell_id  (free_cell_id),
        .free_err      (free_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT grants a cell.
    task automatic sb_pop(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_id: got %0d expected no grant (scoreboard empty)", tag, alloc_cell_id);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_id"}, 32'(alloc_cell_id), 32'(e));
        end
    endtask

    task automatic alloc_one(input logic exp_gnt, input string tag);
        alloc_req = 1'b1;
        #1;
        chk({tag, "_gnt"}, 32'(alloc_gnt), 32'(exp_gnt));
        if (alloc_gnt) sb_pop(tag);
        @(posedge clk); #1;
        alloc_req = 1'b0;
    endtask

    task automatic free_one(input int port, input logic [W-1:0] id, input logic exp_rdy, input string tag);
        free_req = NP'(1 << port);
        free_cell_id = '0;
        free_cell_id[port*W +: W] = id;
        #1;
        chk({tag, "_ready"}, 32'(free_ready[port]), 32'(exp_rdy));
        if (free_ready[port]) exp_q.push_back(id);
        @(posedge clk); #1;
        free_req = '0;
    endtask

    task automatic wait_init(input string tag);
        int unsigned n;
        n = 0;
        while (!init_done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (!init_done) begin
                chk({tag, "_gnt_in_init"}, 32'(alloc_gnt), 32'd0);
                chk({tag, "_ready_in_init"}, 32'(free_ready), 32'd0);
            end
            if (n == 32) chk({tag, "_count_mid_init"}, 32'(free_count), 32'd32);
        end
        chk({tag, "_init_cycles"}, n, 32'd64);
        chk({tag, "_count_after_init"}, 32'(free_count), 32'd64);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            vecs[k].req       = 4'hF;
            vecs[k].exp_ready = NP'(1 << (k % 4));
            for (int p = 0; p < 4; p++) vecs[k].ids[p*W +: W] = W'(k*4 + p);
        end

        rst = 1'b1; alloc_req = 1'b0; free_req = '0; free_cell_id = '0;
        repeat (3) @(posedge clk);
        #1;
        alloc_req = 1'b1; free_req = 4'hF;
        #1;
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_free_count", 32'(free_count), 32'd0);
        chk("rst_intense", 32'(alloc_intense), 32'd1);
        chk("rst_gnt", 32'(alloc_gnt), 32'd0);
        chk("rst_ready", 32'(free_ready), 32'd0);
        chk("rst_err", 32'(free_err), 32'd0);

        // 1: INIT length, then 64 in-order allocs and an empty refusal
        rst = 1'b0;
        wait_init("t1");
        alloc_req = 1'b0; free_req = '0;
        chk("t1_intense_full", 32'(alloc_intense), 32'd0);
        for (int i = 0; i < 64; i++) exp_q.push_back(W'(i));
        for (int i = 0; i < 64; i++) alloc_one(1'b1, "t1_alloc");
        chk("t1_count_empty", 32'(free_count), 32'd0);
        chk("t1_intense_empty", 32'(alloc_intense), 32'd1);
        alloc_one(1'b0, "t1_alloc65");

        // 2: round-robin over four continuously requesting ports
        for (int k = 0; k < 8; k++) begin
            free_req = vecs[k].req;
            free_cell_id = vecs[k].ids;
            #1;
            chk($sformatf("t2_ready_%0d", k), 32'(free_ready), 32'(vecs[k].exp_ready));
            chk($sformatf("t2_err_%0d", k), 32'(free_err), 32'd0);
            for (int p = 0; p < 4; p++)
                if (free_ready[p]) exp_q.push_back(vecs[k].ids[p*W +: W]);
            @(posedge clk); #1;
        end
        free_req = '0;
        chk("t2_count", 32'(free_count), 32'd8);

        // 3: same-cycle alloc and free at count 10, then free-to-alloc latency
        free_one(0, 6'd40, 1'b1, "t3_pre0");
        free_one(0, 6'd41, 1'b1, "t3_pre1");
        chk("t3_count10", 32'(free_count), 32'd10);
        alloc_req = 1'b1; free_req = 4'b0001; free_cell_id = '0; free_cell_id[0 +: W] = 6'd50;
        #1;
        chk("t3_both_gnt", 32'(alloc_gnt), 32'd1);
        if (alloc_gnt) sb_pop("t3_both");
        chk("t3_both_ready", 32'(free_ready), 32'd1);
        if (free_ready[0]) exp_q.push_back(6'd50);
        @(posedge clk); #1;
        alloc_req = 1'b0; free_req = '0;
        chk("t3_count_hold", 32'(free_count), 32'd10);
        for (int i = 0; i < 10; i++) alloc_one(1'b1, "t3_drain");
        chk("t3_count_drained", 32'(free_count), 32'd0);
        alloc_req = 1'b1; free_req = 4'b0100; free_cell_id = '0; free_cell_id[2*W +: W] = 6'd33;
        #1;
        chk("t3_no_bypass_gnt", 32'(alloc_gnt), 32'd0);
        chk("t3_lat_ready", 32'(free_ready), 32'd4);
        if (free_ready[2]) exp_q.push_back(6'd33);
        @(posedge clk); #1;
        free_req = '0;
        alloc_one(1'b1, "t3_lat");

        // 4: pressure flag across the 32/33 boundary, then full
        for (int i = 0; i < 33; i++) begin
            free_one(3, W'(i), 1'b1, "t4_fill");
            if (i == 31) chk("t4_intense_at32", 32'(alloc_intense), 32'd1);
        end
        chk("t4_count33", 32'(free_count), 32'd33);
        chk("t4_intense_32to33", 32'(alloc_intense), 32'd0);
        alloc_one(1'b1, "t4_alloc");
        chk("t4_intense_33to32", 32'(alloc_intense), 32'd1);
        free_one(1, 6'd0, 1'b1, "t4_refree");
        chk("t4_intense_back33", 32'(alloc_intense), 32'd0);
        for (int i = 33; i < 64; i++) free_one(2, W'(i), 1'b1, "t4_tofull");
        chk("t4_count_full", 32'(free_count), 32'd64);
        free_req = 4'hF;
        #1;
        chk("t4_full_ready", 32'(free_ready), 32'd0);
        @(posedge clk); #1;
        free_req = '0;
        chk("t4_count_still_full", 32'(free_count), 32'd64);

        // 5: reset mid-traffic with 20 allocated and frees pending
        for (int i = 0; i < 20; i++) alloc_one(1'b1, "t5_alloc");
        chk("t5_count44", 32'(free_count), 32'd44);
        free_req = 4'hF; free_cell_id = {6'd1, 6'd2, 6'd3, 6'd4};
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_count_after_rst", 32'(free_count), 32'd0);
        chk("t5_init_done_after_rst", 32'(init_done), 32'd0);
        wait_init("t5");
        chk("t5_ready_full", 32'(free_ready), 32'd0);
        free_req = '0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(W'(i));
        for (int i = 0; i < 6; i++) alloc_one(1'b1, "t5_realloc");
        chk("t5_count58", 32'(free_count), 32'd58);

        // 6: double free of ID 5
        free_one(0, 6'd5, 1'b1, "t6_first");
        chk("t6_count_first", 32'(free_count), 32'd59);
`ifdef CELL_ALLOC_DOUBLE_FREE_CHECK_EN
        free_req = 4'b0001; free_cell_id = '0; free_cell_id[0 +: W] = 6'd5;
        #1;
        chk("t6_second_ready", 32'(free_ready), 32'd1);
        chk("t6_second_err", 32'(free_err), 32'd1);
        @(posedge clk); #1;
        free_req = '0;
        chk("t6_err_pulse_end", 32'(free_err), 32'd0);
        chk("t6_count_second", 32'(free_count), 32'd59);
`else
        free_req = 4'b0001; free_cell_id = '0; free_cell_id[0 +: W] = 6'd7;
        #1;
        chk("t6_err_tied", 32'(free_err), 32'd0);
        @(posedge clk); #1;
        free_req = '0;
        chk("t6_count_second", 32'(free_count), 32'd60);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
